// File: rtl/div_unit_32b_pkg.sv
// Shared constants and state encoding for the multi-cycle restoring divider.
package div_unit_32b_pkg;

  localparam int DATA_W = 32;
  localparam int DIV_ITER = 32;
  localparam logic [DATA_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit_32b_if.sv
// Start/busy/done handshake plus operand and result bus between control path and divider.
interface div_unit_32b_if;
  import div_unit_32b_pkg::*;

  logic              start;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] r;
  logic              n;
  logic              z;
  logic              div0;

  modport master (
    output start, a, b,
    input  busy, done, q, r, n, z, div0
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, r, n, z, div0
  );

endinterface

// File: rtl/FullAdder_32b.sv
// Fixed 32-bit adder with carry-in/carry-out, shared with the ALU datapath.
module FullAdder_32b (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        c_i,
  output logic [31:0] sum_o,
  output logic        c_o
);

  assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'b0, c_i};

endmodule

// File: rtl/div_unit_32b.sv
// Unsigned 32-bit restoring divider: one quotient bit per cycle via a trial
// subtraction on the shared adder, with a start/busy/done handshake.
module div_unit_32b
  import div_unit_32b_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic         clk,
  input logic         rst,
  div_unit_32b_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITER - 1);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] q_d;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             n_q;
  logic             z_q;
  logic             div0_q;

  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] diff;
  logic             no_borrow;
  logic             take;

  // Trial subtraction trial - d as trial + ~d + 1; carry-out set means no borrow.
  FullAdder_32b u_sub (
    .a_i   (trial),
    .b_i   (~d_q),
    .c_i   (1'b1),
    .sum_o (diff),
    .c_o   (no_borrow)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    trial = {p_q[WIDTH-2:0], q_q[WIDTH-1]};
    // The shifted-out p_q msb makes the 33-bit partial exceed any 32-bit divisor.
    take  = p_q[WIDTH-1] | no_borrow;
    p_d   = take ? diff : trial;
    q_d   = {q_q[WIDTH-2:0], take};
  end

  // NOTE: all state uses non-blocking assignments so each register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.b != '0) begin
              q_q     <= bus.a;
              d_q     <= bus.b;
              p_q     <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_DIV;
            end else begin
              quo_q   <= DIV0_QUOT;
              rem_q   <= bus.a;
              n_q     <= 1'b1;
              z_q     <= 1'b0;
              div0_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end

        S_DIV: begin
          p_q   <= p_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            quo_q   <= q_d;
            rem_q   <= p_d;
            n_q     <= q_d[WIDTH-1];
            z_q     <= (q_d == '0);
            div0_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.q    = quo_q;
  assign bus.r    = rem_q;
  assign bus.n    = n_q;
  assign bus.z    = z_q;
  assign bus.div0 = div0_q;

endmodule

// File: tb/tb_div_unit_32b.sv
// Directed and randomised checks of div_unit_32b results, flags, latency and handshake.
module tb_div_unit_32b;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_32b_if bus ();

  div_unit_32b #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] oq, orr;
  logic        on, oz, od;
  int          lat, bc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit hold);
    wait_idle();
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
  endtask

  // Sample index 0 is just after the accept edge; lat is the index where done is seen.
  task automatic wait_done(input int idx0);
    int idx = idx0;
    lat = -1;
    bc  = 0;
    while (idx < 100) begin
      if (bus.done) begin
        lat = idx;
        oq  = bus.q;
        orr = bus.r;
        on  = bus.n;
        oz  = bus.z;
        od  = bus.div0;
        break;
      end
      if (bus.busy) bc++;
      @(posedge clk);
      #1;
      idx++;
    end
  endtask

  task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input logic en,
                           input logic ez, input logic ed, input int elat, input int ebc);
    launch(a, b, 1'b0);
    wait_done(0);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_busy"}, bc, ebc);
    check({tag, "_q"}, oq, eq);
    check({tag, "_r"}, orr, er);
    check({tag, "_n"}, {31'b0, on}, {31'b0, en});
    check({tag, "_z"}, {31'b0, oz}, {31'b0, ez});
    check({tag, "_div0"}, {31'b0, od}, {31'b0, ed});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, eq, er;
    int seen;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_q", bus.q, 32'd0);
    check("rst_r", bus.r, 32'd0);
    check("rst_flags", {29'b0, bus.n, bus.z, bus.div0}, 32'd0);
    rst = 1'b0;

    run_check("t1", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 32, 32);
    @(posedge clk);
    #1;
    check("t1_done_pulse", {31'b0, bus.done}, 32'd0);
    check("t1_hold_q", bus.q, 32'd14);
    check("t1_hold_r", bus.r, 32'd2);

    run_check("t2", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 1'b1, 0, 0);

    run_check("t3a", 32'd3, 32'd7, 32'd0, 32'd3, 1'b0, 1'b1, 1'b0, 32, 32);
    run_check("t3b", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0, 32, 32);
    run_check("t3c", 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF,
              1'b0, 1'b0, 1'b0, 32, 32);

    // Start pulse with new operands mid-division must not disturb the running op.
    launch(32'd1000, 32'd10, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a = 32'd7;
    bus.b = 32'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(11);
    check("t4_lat", lat, 32);
    check("t4_q", oq, 32'd100);
    check("t4_r", orr, 32'd0);

    // Start held through DONE is ignored there; dropped before the IDLE edge.
    launch(32'd20, 32'd4, 1'b1);
    wait_done(0);
    check("t4h_lat", lat, 32);
    check("t4h_q", oq, 32'd5);
    @(posedge clk);
    #1;
    check("t4h_busy_after_done", {31'b0, bus.busy}, 32'd0);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check("t4h_busy_idle", {31'b0, bus.busy}, 32'd0);
    check("t4h_done_idle", {31'b0, bus.done}, 32'd0);
    check("t4h_q_hold", bus.q, 32'd5);

    // Reset mid-division aborts with no done pulse.
    launch(32'd50, 32'd5, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_busy", {31'b0, bus.busy}, 32'd0);
    check("t5_done", {31'b0, bus.done}, 32'd0);
    check("t5_q", bus.q, 32'd0);
    check("t5_r", bus.r, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    check("t5_no_activity", seen, 32'd0);
    run_check("t5b", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, 32, 32);

    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin
          a = $urandom_range(0, 1000);
          b = $urandom_range(1001, 100000);
        end
        2: b = 32'd1;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      eq = (b == 0) ? 32'hFFFF_FFFF : a / b;
      er = (b == 0) ? a : a % b;
      launch(a, b, 1'b0);
      wait_done(0);
      check($sformatf("rnd%0d_lat", i), lat, (b == 0) ? 32'd0 : 32'd32);
      check($sformatf("rnd%0d_q", i), oq, eq);
      check($sformatf("rnd%0d_r", i), orr, er);
      check($sformatf("rnd%0d_div0", i), {31'b0, od}, {31'b0, (b == 0)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
